// File: rtl/sys_bus_master.sv
// sys_bus_master: single-outstanding system bus initiator.
// Turns a valid/ready command stream into one-cycle wen/ren strobes, waits
// for the slave ack and returns rdata/err on a valid/ready response stream.
// Optional macro SYS_BUS_MASTER_TIMEOUT_EN adds an ack timeout of TMO cycles
// (counted from the cycle after the strobe); without it WAIT exits only on ack.
//
// state | meaning
// IDLE  | ready for a command (cmd_rdy_o high)
// STRB  | one-cycle wen/ren strobe on the bus
// WAIT  | waiting for bus_ack_i (or timeout)
// RSP   | response held until rsp_rdy_i
module sys_bus_master #(
   parameter int unsigned AW  = 32,
   parameter int unsigned DW  = 32,
   parameter int unsigned TMO = 255
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          cmd_vld_i,
   output logic          cmd_rdy_o,
   input  logic          cmd_wr_i,
   input  logic [AW-1:0] cmd_addr_i,
   input  logic [DW-1:0] cmd_wdata_i,
   output logic          rsp_vld_o,
   input  logic          rsp_rdy_i,
   output logic [DW-1:0] rsp_rdata_o,
   output logic          rsp_err_o,
   output logic          rsp_tmo_o,
   output logic          bus_wen_o,
   output logic          bus_ren_o,
   output logic [AW-1:0] bus_addr_o,
   output logic [DW-1:0] bus_wdata_o,
   input  logic [DW-1:0] bus_rdata_i,
   input  logic          bus_ack_i,
   input  logic          bus_err_i
);

   typedef enum logic [1:0] {IDLE, STRB, WAIT, RSP} state_e;

   // Reject a timeout outside 1..65535 at elaboration
   if (TMO < 1 || TMO > 65535) begin : g_tmo_range
      $error("sys_bus_master: TMO out of range 1..65535");
   end

   state_e          state_q;
   logic            wr_q;
   logic            bus_wen_q;
   logic            bus_ren_q;
   logic [AW-1:0]   bus_addr_q;
   logic [DW-1:0]   bus_wdata_q;
   logic            rsp_vld_q;
   logic [DW-1:0]   rsp_rdata_q;
   logic            rsp_err_q;

`ifdef SYS_BUS_MASTER_TIMEOUT_EN
   localparam int unsigned   CW       = $clog2(TMO + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

   logic [CW-1:0] cnt_q;
   logic          rsp_tmo_q;
`endif

   // cmd_rdy is the only combinational output; forced low while in reset
   assign cmd_rdy_o   = rstn_i && (state_q == IDLE);
   assign rsp_vld_o   = rsp_vld_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign bus_wen_o   = bus_wen_q;
   assign bus_ren_o   = bus_ren_q;
   assign bus_addr_o  = bus_addr_q;
   assign bus_wdata_o = bus_wdata_q;
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
   assign rsp_tmo_o   = rsp_tmo_q;
`else
   assign rsp_tmo_o   = 1'b0;
`endif

   // Transaction FSM with registered bus and response outputs
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= IDLE;
         wr_q        <= 1'b0;
         bus_wen_q   <= 1'b0;
         bus_ren_q   <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         rsp_vld_q   <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
         cnt_q       <= '0;
         rsp_tmo_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_vld_i) begin
                  wr_q        <= cmd_wr_i;
                  bus_addr_q  <= cmd_addr_i;
                  bus_wdata_q <= cmd_wr_i ? cmd_wdata_i : '0;
                  bus_wen_q   <= cmd_wr_i;
                  bus_ren_q   <= !cmd_wr_i;
                  state_q     <= STRB;
               end
            end
            STRB: begin
               // ack seen here belongs to nobody and is ignored
               bus_wen_q <= 1'b0;
               bus_ren_q <= 1'b0;
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
               cnt_q     <= '0;
`endif
               state_q   <= WAIT;
            end
            WAIT: begin
               // ack on the final count cycle takes priority over timeout
               if (bus_ack_i) begin
                  rsp_vld_q   <= 1'b1;
                  rsp_rdata_q <= wr_q ? '0 : bus_rdata_i;
                  rsp_err_q   <= bus_err_i;
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
                  rsp_tmo_q   <= 1'b0;
`endif
                  state_q     <= RSP;
               end
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
               else if (cnt_q == TMO_LAST) begin
                  rsp_vld_q   <= 1'b1;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_tmo_q   <= 1'b1;
                  state_q     <= RSP;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
`endif
            end
            RSP: begin
               if (rsp_rdy_i) begin
                  rsp_vld_q <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sys_bus_master.sv
// Directed bench for sys_bus_master. Inputs change and outputs are sampled on
// the falling clock edge; the slave side is driven by hand as a registered slave.
module tb_sys_bus_master;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic        cmd_wr;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_vld;
   logic        rsp_rdy;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_tmo;
   logic        bus_wen;
   logic        bus_ren;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        bus_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sys_bus_master #(.AW(32), .DW(32), .TMO(8)) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .cmd_vld_i   (cmd_vld),
      .cmd_rdy_o   (cmd_rdy),
      .cmd_wr_i    (cmd_wr),
      .cmd_addr_i  (cmd_addr),
      .cmd_wdata_i (cmd_wdata),
      .rsp_vld_o   (rsp_vld),
      .rsp_rdy_i   (rsp_rdy),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .rsp_tmo_o   (rsp_tmo),
      .bus_wen_o   (bus_wen),
      .bus_ren_o   (bus_ren),
      .bus_addr_o  (bus_addr),
      .bus_wdata_o (bus_wdata),
      .bus_rdata_i (bus_rdata),
      .bus_ack_i   (bus_ack),
      .bus_err_i   (bus_err)
   );

   // Present a command for one cycle; returns on the falling edge of the strobe cycle
   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      cmd_vld = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
      @(negedge clk);
      cmd_vld = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; cmd_vld = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_rdy = 1'b1; bus_rdata = '0; bus_ack = 1'b0; bus_err = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({cmd_rdy, rsp_vld, rsp_err, rsp_tmo, bus_wen, bus_ren} !== 6'b0) begin
         $display("FAIL reset_ctrl got %b exp 000000", {cmd_rdy, rsp_vld, rsp_err, rsp_tmo, bus_wen, bus_ren});
         errors++;
      end
      checks++;
      if ({bus_addr, bus_wdata, rsp_rdata} !== 96'h0) begin
         $display("FAIL reset_data got %h %h %h exp 0", bus_addr, bus_wdata, rsp_rdata);
         errors++;
      end
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_rdy !== 1'b1) begin $display("FAIL reset_rdy got %b exp 1", cmd_rdy); errors++; end
   endtask

   task automatic test_write();
      rsp_rdy = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_rdy !== 1'b1) begin $display("FAIL wr_rdy got %b exp 1", cmd_rdy); errors++; end
      cmd_vld = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h04; cmd_wdata = 32'h2;
      @(negedge clk);
      cmd_vld = 1'b0;
      bus_rdata = 32'hDEAD;
      checks++;
      if ({bus_wen, bus_ren, cmd_rdy, rsp_vld} !== 4'b1000) begin
         $display("FAIL wr_strobe got %b exp 1000", {bus_wen, bus_ren, cmd_rdy, rsp_vld}); errors++;
      end
      checks++;
      if (bus_addr !== 32'h04 || bus_wdata !== 32'h2) begin
         $display("FAIL wr_bus got %h/%h exp 00000004/00000002", bus_addr, bus_wdata); errors++;
      end
      @(negedge clk);
      checks++;
      if ({bus_wen, rsp_vld} !== 2'b00) begin
         $display("FAIL wr_one_cycle got %b exp 00", {bus_wen, rsp_vld}); errors++;
      end
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      checks++;
      if ({rsp_vld, rsp_err, rsp_tmo} !== 3'b100 || rsp_rdata !== 32'h0) begin
         $display("FAIL wr_rsp got vld/err/tmo %b rdata %h exp 100 00000000", {rsp_vld, rsp_err, rsp_tmo}, rsp_rdata);
         errors++;
      end
      @(negedge clk);
      checks++;
      if ({rsp_vld, cmd_rdy} !== 2'b01) begin
         $display("FAIL wr_done got %b exp 01", {rsp_vld, cmd_rdy}); errors++;
      end
   endtask

   task automatic test_read();
      rsp_rdy = 1'b1;
      issue(1'b0, 32'h00, 32'h55);
      checks++;
      if ({bus_ren, bus_wen} !== 2'b10 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
         $display("FAIL rd_strobe got ren/wen %b addr %h wdata %h exp 10 0 0", {bus_ren, bus_wen}, bus_addr, bus_wdata);
         errors++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus_ren !== 1'b0 || rsp_vld !== 1'b0 || bus_addr !== 32'h0) begin
            $display("FAIL rd_wait%0d got ren %b vld %b addr %h exp 0 0 0", i, bus_ren, rsp_vld, bus_addr);
            errors++;
         end
      end
      @(negedge clk);
      bus_ack = 1'b1; bus_rdata = 32'h1;
      checks++;
      if (bus_addr !== 32'h0) begin $display("FAIL rd_addr_hold got %h exp 0", bus_addr); errors++; end
      @(negedge clk);
      bus_ack = 1'b0;
      checks++;
      if ({rsp_vld, rsp_err, rsp_tmo} !== 3'b100 || rsp_rdata !== 32'h1) begin
         $display("FAIL rd_rsp got vld/err/tmo %b rdata %h exp 100 00000001", {rsp_vld, rsp_err, rsp_tmo}, rsp_rdata);
         errors++;
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      rsp_rdy = 1'b0;
      issue(1'b0, 32'h10, 32'h0);
      @(negedge clk);
      bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'hABCD;
      @(negedge clk);
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({rsp_vld, rsp_err, cmd_rdy} !== 3'b110 || rsp_rdata !== 32'hABCD) begin
            $display("FAIL bp_hold%0d got vld/err/rdy %b rdata %h exp 110 0000abcd", i, {rsp_vld, rsp_err, cmd_rdy}, rsp_rdata);
            errors++;
         end
         if (i == 3) begin
            cmd_vld = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h77;
         end
         if (i == 4) cmd_vld = 1'b0;
         @(negedge clk);
      end
      rsp_rdy = 1'b1;
      @(negedge clk);
      checks++;
      if ({rsp_vld, cmd_rdy, bus_wen} !== 3'b010 || bus_addr !== 32'h10) begin
         $display("FAIL bp_release got vld/rdy/wen %b addr %h exp 010 00000010", {rsp_vld, cmd_rdy, bus_wen}, bus_addr);
         errors++;
      end
   endtask

   task automatic test_timeout();
      rsp_rdy = 1'b1;
      bus_rdata = 32'h77;
      issue(1'b0, 32'h08, 32'h0);
`ifdef SYS_BUS_MASTER_TIMEOUT_EN
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_vld !== 1'b0) begin $display("FAIL tmo_early%0d got %b exp 0", i, rsp_vld); errors++; end
      end
      @(negedge clk);
      checks++;
      if ({rsp_vld, rsp_err, rsp_tmo} !== 3'b111 || rsp_rdata !== 32'h0) begin
         $display("FAIL tmo_rsp got vld/err/tmo %b rdata %h exp 111 00000000", {rsp_vld, rsp_err, rsp_tmo}, rsp_rdata);
         errors++;
      end
`else
      begin
         int seen = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_vld !== 1'b0) seen++;
         end
         checks++;
         if (seen != 0 || cmd_rdy !== 1'b0) begin
            $display("FAIL notmo_wait got vld_cycles %0d rdy %b exp 0 0", seen, cmd_rdy); errors++;
         end
      end
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      checks++;
      if ({rsp_vld, rsp_err, rsp_tmo} !== 3'b100 || rsp_rdata !== 32'h77) begin
         $display("FAIL notmo_rsp got vld/err/tmo %b rdata %h exp 100 00000077", {rsp_vld, rsp_err, rsp_tmo}, rsp_rdata);
         errors++;
      end
`endif
      @(negedge clk);
      checks++;
      if ({rsp_vld, cmd_rdy} !== 2'b01) begin
         $display("FAIL tmo_done got %b exp 01", {rsp_vld, cmd_rdy}); errors++;
      end
   endtask

   task automatic test_collision_stray();
      rsp_rdy = 1'b1;
      issue(1'b0, 32'h20, 32'h0);
      repeat (7) @(negedge clk);
      @(negedge clk);
      bus_ack = 1'b1; bus_err = 1'b0; bus_rdata = 32'h5A;
      @(negedge clk);
      bus_ack = 1'b0;
      checks++;
      if ({rsp_vld, rsp_err, rsp_tmo} !== 3'b100 || rsp_rdata !== 32'h5A) begin
         $display("FAIL collide got vld/err/tmo %b rdata %h exp 100 0000005a", {rsp_vld, rsp_err, rsp_tmo}, rsp_rdata);
         errors++;
      end
      @(negedge clk);
      bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'h99;
      @(negedge clk);
      bus_ack = 1'b0; bus_err = 1'b0;
      checks++;
      if ({rsp_vld, cmd_rdy} !== 2'b01) begin
         $display("FAIL stray_ack got vld/rdy %b exp 01", {rsp_vld, cmd_rdy}); errors++;
      end
      issue(1'b0, 32'h0C, 32'h0);
      @(negedge clk);
      bus_ack = 1'b1; bus_rdata = 32'h33;
      @(negedge clk);
      bus_ack = 1'b0;
      checks++;
      if ({rsp_vld, rsp_err, rsp_tmo} !== 3'b100 || rsp_rdata !== 32'h33) begin
         $display("FAIL after_stray got vld/err/tmo %b rdata %h exp 100 00000033", {rsp_vld, rsp_err, rsp_tmo}, rsp_rdata);
         errors++;
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      rsp_rdy = 1'b1;
      for (int d = 1; d <= 3; d += 2) begin
         issue(1'b1, 32'h30, 32'hAA);
         repeat (d - 1) @(negedge clk);
         checks++;
         if (bus_wen !== (d == 1)) begin $display("FAIL arst_pre%0d got wen %b", d, bus_wen); errors++; end
         #2 rstn = 1'b0;
         #1;
         checks++;
         if ({bus_wen, bus_ren, rsp_vld, cmd_rdy} !== 4'b0000 || bus_addr !== 32'h0) begin
            $display("FAIL arst_now%0d got wen/ren/vld/rdy %b addr %h exp 0000 0", d, {bus_wen, bus_ren, rsp_vld, cmd_rdy}, bus_addr);
            errors++;
         end
         @(negedge clk);
         rstn = 1'b1;
         bus_ack = 1'b1;
         @(negedge clk);
         bus_ack = 1'b0;
         checks++;
         if (cmd_rdy !== 1'b1) begin $display("FAIL arst_rdy%0d got %b exp 1", d, cmd_rdy); errors++; end
         begin
            int seen = 0;
            repeat (4) begin
               @(negedge clk);
               if (rsp_vld !== 1'b0) seen++;
            end
            checks++;
            if (seen != 0) begin $display("FAIL arst_norsp%0d got vld_cycles %0d exp 0", d, seen); errors++; end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_backpressure();
      test_timeout();
      test_collision_stray();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sys_bus_master.md
Name: sys_bus_master

Overview:
- Single-outstanding initiator for the system bus; the other end of the register slaves (mux control, GPIO, generators) that answer strobes with a registered ack/rdata/err.
- Converts a valid/ready command stream (from a debug/JTAG bridge or an init sequencer) into one-cycle wen/ren strobes.
- Waits for ack and returns rdata/err on a valid/ready response stream.

Parameters:
- AW, 32, bus address width
- DW, 32, bus data width
- TMO, 255, ack timeout in clk cycles, counted from the cycle after the strobe; range 1..65535

Ports:
- clk        in   1   system clock
- rstn       in   1   asynchronous active-low reset
- cmd_vld    in   1   command valid
- cmd_rdy    out  1   command ready
- cmd_wr     in   1   1=write, 0=read
- cmd_addr   in   AW  command address
- cmd_wdata  in   DW  write data (ignored for reads)
- rsp_vld    out  1   response valid
- rsp_rdy    in   1   response ready
- rsp_rdata  out  DW  read data (0 for writes and on timeout)
- rsp_err    out  1   bus err, or timeout
- rsp_tmo    out  1   timeout flag
- bus_wen    out  1   write strobe
- bus_ren    out  1   read strobe
- bus_addr   out  AW  bus address
- bus_wdata  out  DW  bus write data
- bus_rdata  in   DW  slave read data
- bus_ack    in   1   slave acknowledge
- bus_err    in   1   slave error

Behaviour:
- Reset: single clk domain; reset asynchronous active-low on rstn, release synchronous to clk.
  - All outputs are 0 in reset, including bus_addr, bus_wdata and rsp_*.
  - State returns to IDLE.
  - An in-flight transaction is dropped with no response.
- All outputs are registered, except cmd_rdy = (state==IDLE).
- FSM states: IDLE, STRB, WAIT, RSP.
- IDLE:
  - On cmd_vld&&cmd_rdy: latch wr/addr/wdata, then go to STRB.
  - Next-cycle bus_addr/bus_wdata take the latched values; bus_wdata = 0 for reads.
- STRB (exactly one cycle):
  - bus_wen=cmd_wr, bus_ren=!cmd_wr.
  - Go to WAIT and clear the timeout counter.
  - bus_ack in this cycle is ignored.
- WAIT:
  - bus_wen/bus_ren = 0; bus_addr/bus_wdata held stable.
  - On bus_ack: rsp_rdata = read ? bus_rdata : 0; rsp_err = bus_err; rsp_tmo = 0; rsp_vld = 1; go to RSP.
  - Else counter++. When counter reaches TMO-1 without ack: rsp_rdata = 0, rsp_err = 1, rsp_tmo = 1, rsp_vld = 1; go to RSP.
  - Ack in the same cycle as the final count wins over timeout.
- RSP:
  - rsp_* held stable while !rsp_rdy.
  - On rsp_rdy: rsp_vld = 0, go to IDLE; bus_addr/bus_wdata keep their last values.
  - bus_ack in IDLE or RSP is ignored (stray ack).
- Latency: minimum command-accept to rsp_vld is 3 cycles with a zero-wait slave (accept, strobe, ack → rsp_vld).
- Throughput: one transaction per 4 cycles with rsp_rdy held high.
- Exactly one transaction is outstanding; a new command is never accepted before the response handshake completes.
- Counter width: $clog2(TMO+1) bits; it never wraps because it saturates at the terminal state.
- Late ack after a timeout:
  - If the late ack lands in IDLE/RSP, it is discarded.
  - If it lands in the WAIT of the next transaction, it is attributed to that transaction. This is a documented limitation; software must treat a timeout as fatal for that slave.
- Mid-transaction reset: the strobe is deasserted immediately (async); no response is generated.

Optional Feature:
- Macro: SYS_BUS_MASTER_TIMEOUT_EN.
- Defined: timeout counter and rsp_tmo behave as above.
- Undefined:
  - No counter is instantiated; WAIT exits only on bus_ack.
  - rsp_tmo is tied 0 and rsp_err reflects bus_err only.
  - The TMO parameter is unused.

Test Plan:
- Write: cmd_wr=1, addr=0x04, wdata=0x2, zero-wait slave, rsp_rdy=1 → bus_wen high exactly one cycle with addr 0x04 and wdata 0x2; rsp_vld 3 cycles after accept with err=0, tmo=0, rdata=0.
- Read: cmd_wr=0, addr=0x00, slave returns rdata=0x1 after 5 wait cycles → bus_ren one cycle; addr held through ack; rsp_rdata=0x1, err=0.
- Backpressure: read with slave err=1 and rsp_rdy low for 10 cycles → rsp_vld, rsp_err=1 and rdata stable for all 10 cycles; cmd_rdy=0 throughout; a cmd_vld pulse meanwhile is not accepted.
- Timeout: TMO=8, slave never acks → rsp_vld with err=1, tmo=1, rdata=0 on the cycle after counter reaches 7. Without the macro → bench stays in WAIT for 100 cycles with no rsp_vld.
- Ack/timeout collision, then stray ack: ack on the final count cycle → tmo=0, err=bus_err. Then a stray ack in IDLE followed by a new read → the stray ack is ignored and the read completes with the correct rdata.
- Async reset: assert rstn low during WAIT → bus_ren/bus_wen, rsp_vld, cmd_rdy low immediately. After release: cmd_rdy=1 the first cycle, no spurious response.
